timer_regs_ctrl: RTL and testbench
==================================

Name: timer_regs_ctrl

Overview:
Register-level controller for the Game Boy timer unit. It owns the DIV/TIMA/TMA/TAC registers at FF04–FF07 and advances them once per CPU machine cycle. It sequences TIMA overflow and TMA reload, and raises the 0x50 timer interrupt towards the interrupt controller. It sits beside the CPU's M-cycle accounting logic, consumes its per-M-cycle tick, and serves CPU bus reads and writes.

Parameters:
ADDR_BASE, 16'hFF04, address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.
SYS_BITS, 14, width of the internal M-cycle system counter; DIV = sys[13:6].

Ports:
iClock  input  1  system clock
iReset  input  1  asynchronous, active-low reset
iTick  input  1  one-cycle pulse per CPU M-cycle; all state advances only when iTick=1
iAddr  input  16  CPU bus address
iWe  input  1  write strobe, sampled only when iTick=1
iData  input  8  write data
oData  output  8  read data (combinational)
oHit  output  1  iAddr within FF04–FF07
iIntAck  input  1  interrupt controller acknowledge pulse for vector 0x50
oInterrupt0x50  output  1  timer interrupt request, level

Behaviour:
- Reset (iReset=0, asynchronous):
  - sys=0, TIMA=0, TMA=0, TAC=0, state=RUN.
  - oInterrupt0x50=0.
  - The internal edge register prev=0.
- Nothing changes on cycles with iTick=0, except that a pending iIntAck is still honoured (see interrupt handshake).
- System counter: on each tick, sys = sys+1, wrapping mod 2^SYS_BITS. A DIV write (any data) sets sys=0 on that tick instead of incrementing.
- Selected bit sel, chosen by TAC[1:0]:
  - 00 → sys[7] (every 256 M-cycles)
  - 01 → sys[1] (every 4)
  - 10 → sys[3] (every 16)
  - 11 → sys[5] (every 64)
- Edge detection:
  - cur = TAC[2] & sel, evaluated on the post-update sys and TAC.
  - A falling edge (prev=1, cur=0) increments TIMA; prev<=cur on every tick.
  - Consequence: a DIV reset, a TAC disable, or a TAC select change can produce a spurious increment. This is required hardware-accurate behaviour.
- TIMA overflow FSM, one transition per tick:
  - RUN: an increment at TIMA=FF sets TIMA=00 and moves to OVF. Otherwise stay in RUN.
  - OVF (TIMA reads 00 for exactly one M-cycle):
    - CPU write to TIMA → TIMA=iData, reload and IRQ cancelled, go to RUN.
    - Otherwise TIMA=TMA (the TMA value including any same-tick TMA write), set oInterrupt0x50=1, go to RLD.
  - RLD (one M-cycle):
    - CPU writes to TIMA are ignored.
    - CPU writes to TMA also load TIMA.
    - Always go to RUN.
    - A timer increment in RLD applies normally.
- A CPU write to TIMA in RUN on the same tick as an increment: the write wins and the increment is dropped.
- Reads (oData, combinational):
  - DIV = sys[13:6], TIMA, TMA.
  - TAC = {5'b11111, TAC[2:0]}.
  - When oHit=0, oData=8'h00.
- TAC writes store iData[2:0] only.
- Interrupt handshake:
  - oInterrupt0x50 stays 1 until an iIntAck cycle clears it. The ack acts on any clock, regardless of iTick.
  - If a new request and an ack occur on the same clock, the request wins and the output remains 1.
- Mid-operation reset: asynchronous return to all reset values; a pending overflow is discarded.

Decomposition:
- Shared definitions header (alongside the existing definitions include): the four register address constants, the TAC select encodings, and the FSM state encodings RUN/OVF/RLD.
- One natural sub-module, timer_edge_select:
  - Contains the TAC mux, the enable AND, the prev flop and the falling-edge output.
  - Is reusable by the serial and audio frame-sequencer blocks.

Test Plan:
1. Reset, then 64 ticks with no writes → DIV reads 8'h01; TIMA 00; oInterrupt0x50=0.
2. TAC=3'b101, TMA=8'hF0, TIMA=8'hFE; tick until 2 increments → TIMA=00 for one tick, then F0 with oInterrupt0x50=1. iIntAck then clears it.
3. Same setup; write TIMA=8'h33 during the OVF tick → TIMA=33, no reload, no interrupt.
4. During the RLD tick, write TIMA=8'h55 → ignored, TIMA=F0. Separately, write TMA=8'hAA in RLD → TIMA=AA.
5. TAC=3'b110; run until sys[3]=1; write DIV → TIMA increments by 1 and DIV reads 00. Write TAC=3'b010 while sys[3]=1 → one spurious increment.
6. Request and iIntAck on the same clock → oInterrupt0x50 stays 1. Assert iReset=0 mid-OVF → all registers 0, output 0, state RUN. A TAC read after reset returns 8'hF8.

Source files
------------

// File: rtl/timer_regs_ctrl_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer block: register offsets,
// TAC select encodings and overflow-sequencer state encodings.
package timer_regs_ctrl_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  // TAC[1:0] clock select; names give the period in M-cycles
  localparam logic [1:0] TAC_SEL_256 = 2'b00;
  localparam logic [1:0] TAC_SEL_4   = 2'b01;
  localparam logic [1:0] TAC_SEL_16  = 2'b10;
  localparam logic [1:0] TAC_SEL_64  = 2'b11;

  typedef logic [1:0] tstate_t;

  localparam tstate_t ST_RUN = 2'd0;
  localparam tstate_t ST_OVF = 2'd1;
  localparam tstate_t ST_RLD = 2'd2;

  function automatic logic [7:0] tac_readback(input logic [2:0] tac);
    return {5'b11111, tac};
  endfunction

endpackage

// File: rtl/timer_edge_select.sv
// Tap-select mux gated by an enable, with a falling-edge detector that
// advances only on tick cycles. Shared by the timer, serial and frame sequencer.
module timer_edge_select (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       en_i,
  input  logic [1:0] sel_i,
  input  logic [3:0] taps_i,
  output logic       fall_o
);

  logic prev_q, prev_d;
  logic cur;

  always_comb begin
    cur    = en_i & taps_i[sel_i];
    prev_d = tick_i ? cur : prev_q;
    fall_o = tick_i & prev_q & ~cur;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

endmodule

// File: rtl/timer_regs_ctrl.sv
// Game Boy timer register block (DIV/TIMA/TMA/TAC) with TIMA overflow/reload
// sequencing and the level-held 0x50 interrupt request.
module timer_regs_ctrl
  import timer_regs_ctrl_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'hFF04,
  parameter int unsigned SYS_BITS  = 14
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iTick,
  input  logic [15:0] iAddr,
  input  logic        iWe,
  input  logic [7:0]  iData,
  output logic [7:0]  oData,
  output logic        oHit,
  input  logic        iIntAck,
  output logic        oInterrupt0x50
);

  logic [SYS_BITS-1:0] sys_q, sys_d;
  logic [7:0]          tima_q, tima_d, tma_q, tma_d;
  logic [2:0]          tac_q, tac_d;
  tstate_t             state_q, state_d;
  logic                irq_q, irq_d, irq_set;
  logic [15:0]         offset;
  logic                wr, wr_div, wr_tima, wr_tma, wr_tac;
  logic                inc;
  logic [7:0]          rld_base;

  assign offset = iAddr - ADDR_BASE;
  assign oHit   = (offset[15:2] == '0);
  assign wr     = iTick & iWe & oHit;
  assign wr_div  = wr & (offset[1:0] == REG_DIV);
  assign wr_tima = wr & (offset[1:0] == REG_TIMA);
  assign wr_tma  = wr & (offset[1:0] == REG_TMA);
  assign wr_tac  = wr & (offset[1:0] == REG_TAC);

  always_comb begin
    sys_d = sys_q;
    if (iTick) sys_d = wr_div ? '0 : sys_q + SYS_BITS'(1);
    tac_d = wr_tac ? iData[2:0] : tac_q;
    tma_d = wr_tma ? iData : tma_q;
  end

  // Edge detection sees the post-update counter and TAC, so DIV resets and
  // TAC changes on this tick can create the hardware's spurious increment.
  timer_edge_select u_edge (
    .clk_i  (iClock),
    .rst_ni (iReset),
    .tick_i (iTick),
    .en_i   (tac_d[2]),
    .sel_i  (tac_d[1:0]),
    .taps_i ({sys_d[5], sys_d[3], sys_d[1], sys_d[7]}),
    .fall_o (inc)
  );

  always_comb begin
    state_d  = state_q;
    tima_d   = tima_q;
    irq_set  = 1'b0;
    rld_base = wr_tma ? iData : tima_q;
    case (state_q)
      ST_RUN: begin
        if (wr_tima) begin
          tima_d = iData;
        end else if (inc) begin
          if (tima_q == 8'hFF) begin
            tima_d  = '0;
            state_d = ST_OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (iTick) begin
          if (wr_tima) begin
            tima_d  = iData;
            state_d = ST_RUN;
          end else begin
            tima_d  = tma_d;
            irq_set = 1'b1;
            state_d = ST_RLD;
          end
        end
      end
      ST_RLD: begin
        if (iTick) begin
          tima_d  = inc ? rld_base + 8'd1 : rld_base;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    irq_d = irq_set | (irq_q & ~iIntAck);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      sys_q   <= '0;
      tima_q  <= '0;
      tma_q   <= '0;
      tac_q   <= '0;
      state_q <= ST_RUN;
      irq_q   <= 1'b0;
    end else begin
      sys_q   <= sys_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    oData = '0;
    if (oHit) begin
      case (offset[1:0])
        REG_DIV:  oData = sys_q[SYS_BITS-1 -: 8];
        REG_TIMA: oData = tima_q;
        REG_TMA:  oData = tma_q;
        default:  oData = tac_readback(tac_q);
      endcase
    end
  end

  assign oInterrupt0x50 = irq_q;

endmodule

// File: tb/tb_timer_regs_ctrl.sv
// Directed bench for timer_regs_ctrl: expectations queued at stimulus time,
// popped and asserted when the DUT output is sampled.
module tb_timer_regs_ctrl;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iTick = 1'b0;
  logic [15:0] iAddr = 16'h0000;
  logic        iWe = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic [7:0]  oData;
  logic        oHit;
  logic        iIntAck = 1'b0;
  logic        oInterrupt0x50;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  timer_regs_ctrl #(.ADDR_BASE(16'hFF04), .SYS_BITS(14)) dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iTick          (iTick),
    .iAddr          (iAddr),
    .iWe            (iWe),
    .iData          (iData),
    .oData          (oData),
    .oHit           (oHit),
    .iIntAck        (iIntAck),
    .oInterrupt0x50 (oInterrupt0x50)
  );

  always #5 iClock = ~iClock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic compare(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: observed empty expected entry");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_rd(input string tag, input logic [15:0] a, input logic [7:0] e);
    sb.push_back('{tag, e});
    iAddr = a;
    #1;
    compare(oData);
  endtask

  task automatic expect_irq(input string tag, input logic e);
    sb.push_back('{tag, {7'b0, e}});
    #1;
    compare({7'b0, oInterrupt0x50});
  endtask

  task automatic expect_hit(input string tag, input logic [15:0] a, input logic e);
    sb.push_back('{tag, {7'b0, e}});
    iAddr = a;
    #1;
    compare({7'b0, oHit});
  endtask

  task automatic do_tick(input logic we, input logic [15:0] a, input logic [7:0] d);
    @(negedge iClock);
    iTick = 1'b1; iWe = we; iAddr = a; iData = d;
    @(negedge iClock);
    iTick = 1'b0; iWe = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) do_tick(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock);
    iReset = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge iClock);
    iIntAck = 1'b1;
    @(negedge iClock);
    iIntAck = 1'b0;
  endtask

  // Ticks 1..3 after reset; falling edges of sys[1] land on ticks 4 and 8.
  task automatic setup_ovf();
    do_reset();
    do_tick(1'b1, A_TAC,  8'h05);
    do_tick(1'b1, A_TMA,  8'hF0);
    do_tick(1'b1, A_TIMA, 8'hFE);
  endtask

  initial begin
    // 1: reset values and free-running DIV
    do_reset();
    expect_rd("rst_div", A_DIV, 8'h00);
    expect_rd("rst_tima", A_TIMA, 8'h00);
    expect_rd("rst_tac", A_TAC, 8'hF8);
    expect_irq("rst_irq", 1'b0);
    run(64);
    expect_rd("div_64", A_DIV, 8'h01);
    expect_rd("tima_64", A_TIMA, 8'h00);
    expect_irq("irq_64", 1'b0);
    expect_hit("hit_ff07", 16'hFF07, 1'b1);
    expect_hit("hit_ff08", 16'hFF08, 1'b0);
    expect_hit("hit_ff03", 16'hFF03, 1'b0);
    expect_rd("miss_data", 16'hFF08, 8'h00);
    do_tick(1'b1, 16'hFF08, 8'h77);
    expect_rd("miss_wr_tma", A_TMA, 8'h00);

    // 2: overflow, reload, interrupt and ack
    setup_ovf();
    run(1);
    expect_rd("inc_1", A_TIMA, 8'hFF);
    run(3);
    expect_rd("hold_ff", A_TIMA, 8'hFF);
    run(1);
    expect_rd("ovf_zero", A_TIMA, 8'h00);
    expect_irq("ovf_irq", 1'b0);
    run(1);
    expect_rd("rld_tma", A_TIMA, 8'hF0);
    expect_irq("rld_irq", 1'b1);
    pulse_ack();
    expect_irq("ack_clr", 1'b0);

    // 3: TIMA write during OVF cancels reload
    setup_ovf();
    run(5);
    do_tick(1'b1, A_TIMA, 8'h33);
    expect_rd("ovf_wr_tima", A_TIMA, 8'h33);
    expect_irq("ovf_wr_irq", 1'b0);
    run(1);
    expect_rd("ovf_wr_after", A_TIMA, 8'h33);
    expect_irq("ovf_wr_irq2", 1'b0);

    // 4: writes during RLD
    setup_ovf();
    run(6);
    do_tick(1'b1, A_TIMA, 8'h55);
    expect_rd("rld_tima_ign", A_TIMA, 8'hF0);
    setup_ovf();
    run(6);
    do_tick(1'b1, A_TMA, 8'hAA);
    expect_rd("rld_tma_tima", A_TIMA, 8'hAA);
    expect_rd("rld_tma_tma", A_TMA, 8'hAA);

    // 5: spurious increments from DIV write and TAC disable
    do_reset();
    do_tick(1'b1, A_TAC, 8'h06);
    run(7);
    expect_rd("sys3_pre", A_TIMA, 8'h00);
    do_tick(1'b1, A_DIV, 8'h5A);
    expect_rd("div_wr_inc", A_TIMA, 8'h01);
    expect_rd("div_wr_zero", A_DIV, 8'h00);
    run(8);
    expect_rd("sys3_again", A_TIMA, 8'h01);
    do_tick(1'b1, A_TAC, 8'hFA);
    expect_rd("tac_dis_inc", A_TIMA, 8'h02);
    expect_rd("tac_masked", A_TAC, 8'hFA);

    // 6: request and ack on the same clock, then reset mid-OVF
    setup_ovf();
    run(5);
    @(negedge iClock);
    iTick = 1'b1; iIntAck = 1'b1;
    @(negedge iClock);
    iTick = 1'b0; iIntAck = 1'b0;
    expect_irq("req_vs_ack", 1'b1);
    expect_rd("req_vs_ack_tima", A_TIMA, 8'hF0);
    setup_ovf();
    run(5);
    expect_rd("pre_rst_ovf", A_TIMA, 8'h00);
    #2 iReset = 1'b0;
    expect_rd("mid_rst_div", A_DIV, 8'h00);
    expect_rd("mid_rst_tima", A_TIMA, 8'h00);
    expect_rd("mid_rst_tma", A_TMA, 8'h00);
    expect_rd("mid_rst_tac", A_TAC, 8'hF8);
    expect_irq("mid_rst_irq", 1'b0);
    @(negedge iClock);
    iReset = 1'b1;
    run(1);
    expect_irq("post_rst_no_irq", 1'b0);
    expect_rd("post_rst_tima", A_TIMA, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
